// File: rtl/mac_arb_pkg.sv
// Shared types and default constants for the MAC job arbiter.
package mac_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int ARB_NUM_REQ     = 4;
    localparam int ARB_DATA_W      = 16;
    localparam int ARB_TIMEOUT_CYC = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter. Owns last_ptr; the search starts at
// last_ptr+1 and wraps. last_ptr only moves when the job completes
// (update), so a job that is aborted by reset does not shift priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       update,
    input  logic [$clog2(NUM_REQ)-1:0] upd_id,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] last_ptr_r;
    logic [ID_W-1:0] idx_s;
    logic            found_s;

    // Priority search: first requester after last_ptr, wrapping modulo NUM_REQ
    always_comb begin
        gnt     = {NUM_REQ{1'b0}};
        gnt_id  = {ID_W{1'b0}};
        found_s = 1'b0;
        idx_s   = {ID_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_W'((int'(last_ptr_r) + k) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Remember the last served requester; reset so requester 0 goes first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ptr_r <= ID_W'(NUM_REQ - 1);
        end else if (update) begin
            last_ptr_r <= upd_id;
        end else begin
            last_ptr_r <= last_ptr_r;
        end
    end

endmodule

// File: rtl/mac_job_arbiter.sv
// Round-robin front end sharing one start/done series-evaluation engine
// among NUM_REQ requesters. One job in flight at a time.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a job whose engine
// never signals done within TIMEOUT_CYC WAIT cycles (rsp_err=1, rsp_data=0).
module mac_job_arbiter
    import mac_arb_pkg::*;
#(
    parameter int NUM_REQ     = ARB_NUM_REQ,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eng_start,
    output logic [DATA_W-1:0]          eng_x,
    input  logic                       eng_ready,
    input  logic                       eng_done,
    input  logic [DATA_W-1:0]          eng_result,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("mac_job_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_t         state_r;
    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_id_s;
    logic               hs_s;
    logic               upd_s;
    logic               timeout_s;
    logic [DATA_W-1:0]  ops_s [NUM_REQ];

    logic               eng_start_r;
    logic [DATA_W-1:0]  eng_x_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [DATA_W-1:0]  rsp_data_r;
    logic               busy_r;
    logic [ID_W-1:0]    grant_id_r;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
        assign ops_s[g] = req_data[g*DATA_W +: DATA_W];
    end

    // A grant is only offered while idle and the engine is ready to begin
    assign hs_s      = (state_r == IDLE) && eng_ready && (|req_valid);
    assign req_ready = hs_s ? gnt_s : {NUM_REQ{1'b0}};
    assign upd_s     = (state_r == RESP);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .update (upd_s),
        .upd_id (grant_id_r),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             rsp_err_r;

    // cnt_r holds the number of WAIT cycles already elapsed
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog counter: cleared on entry to WAIT, counts WAIT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ISSUE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Error flag for the response: done beats a coincident timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_r <= 1'b0;
        end else if ((state_r == WAIT) && eng_done) begin
            rsp_err_r <= 1'b0;
        end else if ((state_r == WAIT) && timeout_s) begin
            rsp_err_r <= 1'b1;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    assign timeout_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Job sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            eng_start_r <= 1'b0;
            eng_x_r     <= {DATA_W{1'b0}};
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            grant_id_r  <= {ID_W{1'b0}};
        end else begin
            eng_start_r <= 1'b0;
            rsp_valid_r <= {NUM_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        eng_x_r     <= ops_s[gnt_id_s];
                        grant_id_r  <= gnt_id_s;
                        eng_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        rsp_data_r              <= eng_result;
                        rsp_valid_r[grant_id_r] <= 1'b1;
                        state_r                 <= RESP;
                    end else if (timeout_s) begin
                        rsp_data_r              <= {DATA_W{1'b0}};
                        rsp_valid_r[grant_id_r] <= 1'b1;
                        state_r                 <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign eng_start = eng_start_r;
    assign eng_x     = eng_x_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;

endmodule
